// File: rtl/apb_ddr_mgmt_pkg.sv
// Shared types, register layout and address map of the DDR management block.
package apb_ddr_mgmt_pkg;
    import types_amba_pkg::*;

    typedef enum logic [1:0] {
        CHN_IDLE = 2'd0,
        CHN_REF  = 2'd1,
        CHN_ZQ   = 2'd2
    } chn_state_e;

    typedef struct packed {
        logic        sr_en;
        logic        auto_ref_en;
        logic        irq_en;
        logic [15:0] ref_period;
        logic [11:0] temp_limit;
    } chn_regs_t;

    localparam chn_regs_t CHN_REGS_RST = '{
        sr_en:       1'b0,
        auto_ref_en: 1'b0,
        irq_en:      1'b0,
        ref_period:  16'd7800,
        temp_limit:  12'hFFF
    };

    localparam logic [11:0] ADDR_ID         = 12'h000;
    localparam logic [5:0]  CHN_WINDOW      = 6'b000001;
    localparam logic [3:0]  OFF_STATUS      = 4'h0;
    localparam logic [3:0]  OFF_CTRL        = 4'h4;
    localparam logic [3:0]  OFF_REF_PERIOD  = 4'h8;
    localparam logic [3:0]  OFF_TEMP_LIMIT  = 4'hC;

    localparam int CTRL_SR_EN    = 0;
    localparam int CTRL_REF_NOW  = 1;
    localparam int CTRL_ZQ_NOW   = 2;
    localparam int CTRL_AUTO_REF = 3;
    localparam int CTRL_IRQ_EN   = 4;
    localparam int CTRL_CLR      = 8;

    function automatic logic [31:0] ctrlReadback(input chn_regs_t regs);
        return {27'd0, regs.irq_en, regs.auto_ref_en, 2'b00, regs.sr_en};
    endfunction

endpackage

// File: rtl/types_amba_pkg.sv
// Minimal AMBA APB request/response types shared by APB slaves in this slice.
package types_amba_pkg;

    typedef struct packed {
        logic        psel;
        logic        penable;
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
    } apb_in_type;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
    } apb_out_type;

endpackage

// File: rtl/apb_ddr_mgmt_chn.sv
// One DDR channel: maintenance request FSM, auto-refresh timer and sticky alarms.
module apb_ddr_mgmt_chn
    import apb_ddr_mgmt_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        srEn_i,
    input  logic        autoRefEn_i,
    input  logic        irqEn_i,
    input  logic [15:0] refPeriod_i,
    input  logic [11:0] tempLimit_i,
    input  logic [11:0] deviceTemp_i,
    input  logic        refNow_i,
    input  logic        zqNow_i,
    input  logic        clrSticky_i,
    input  logic        autoLoad_i,
    input  logic        refAck_i,
    input  logic        zqAck_i,
    output logic        refReq_o,
    output logic        zqReq_o,
    output logic        tempAlarm_o,
    output logic        refMissed_o,
    output logic        irq_o
);

    chn_state_e  state_q;
    logic        refPend_q;
    logic        zqPend_q;
    logic        refMissed_q;
    logic        tempAlarm_q;
    logic        refReq_q;
    logic        zqReq_q;
    logic [15:0] refCnt_q;

    logic timerExpire;
    logic refSet;
    logic tempOver;

    // A zero period parks the timer; a load in the same cycle supersedes expiry.
    assign timerExpire = autoRefEn_i && !autoLoad_i && (refPeriod_i != 16'd0) && (refCnt_q == 16'd0);
    assign refSet      = refNow_i | timerExpire;
    assign tempOver    = deviceTemp_i > tempLimit_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= CHN_IDLE;
            refPend_q   <= 1'b0;
            zqPend_q    <= 1'b0;
            refMissed_q <= 1'b0;
            tempAlarm_q <= 1'b0;
            refReq_q    <= 1'b0;
            zqReq_q     <= 1'b0;
            refCnt_q    <= 16'd0;
        end else begin
            if (autoLoad_i) begin
                refCnt_q <= refPeriod_i;
            end else if (!autoRefEn_i) begin
                refCnt_q <= 16'd0;
            end else if (refPeriod_i != 16'd0) begin
                refCnt_q <= (refCnt_q == 16'd0) ? refPeriod_i : refCnt_q - 16'd1;
            end

            refMissed_q <= (timerExpire & refPend_q) | (refMissed_q & ~clrSticky_i);
            tempAlarm_q <= tempOver | (tempAlarm_q & ~clrSticky_i);
            refPend_q   <= refPend_q | refSet;
            zqPend_q    <= zqPend_q | zqNow_i;

            // Requests set in the same cycle are acted on immediately; refresh wins over ZQ.
            case (state_q)
                CHN_IDLE: begin
                    if (!srEn_i) begin
                        if (refPend_q || refSet) begin
                            state_q  <= CHN_REF;
                            refReq_q <= 1'b1;
                        end else if (zqPend_q || zqNow_i) begin
                            state_q <= CHN_ZQ;
                            zqReq_q <= 1'b1;
                        end
                    end
                end
                CHN_REF: begin
                    if (refAck_i) begin
                        state_q   <= CHN_IDLE;
                        refReq_q  <= 1'b0;
                        refPend_q <= 1'b0;
                    end
                end
                CHN_ZQ: begin
                    if (zqAck_i) begin
                        state_q  <= CHN_IDLE;
                        zqReq_q  <= 1'b0;
                        zqPend_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= CHN_IDLE;
                    refReq_q <= 1'b0;
                    zqReq_q  <= 1'b0;
                end
            endcase
        end
    end

    assign refReq_o    = refReq_q;
    assign zqReq_o     = zqReq_q;
    assign tempAlarm_o = tempAlarm_q;
    assign refMissed_o = refMissed_q;
    assign irq_o       = irqEn_i & (tempAlarm_q | refMissed_q);

endmodule

// File: rtl/apb_ddr_mgmt.sv
// APB register front-end for CHN_TOTAL DDR controller channels; one FSM per channel.
module apb_ddr_mgmt
    import types_amba_pkg::*;
    import apb_ddr_mgmt_pkg::*;
#(
    parameter int          CHN_TOTAL      = 2,
    parameter logic [15:0] REF_PERIOD_RST = 16'd7800
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  apb_in_type                i_apbi,
    output apb_out_type               o_apbo,
    input  logic [CHN_TOTAL-1:0]      i_pll_locked,
    input  logic [CHN_TOTAL-1:0]      i_init_calib_done,
    input  logic [12*CHN_TOTAL-1:0]   i_device_temp,
    input  logic [CHN_TOTAL-1:0]      i_sr_active,
    input  logic [CHN_TOTAL-1:0]      i_ref_ack,
    input  logic [CHN_TOTAL-1:0]      i_zq_ack,
    output logic [CHN_TOTAL-1:0]      o_sr_req,
    output logic [CHN_TOTAL-1:0]      o_ref_req,
    output logic [CHN_TOTAL-1:0]      o_zq_req,
    output logic                      o_irq
);

    chn_regs_t                  regs_q [CHN_TOTAL];
    logic [CHN_TOTAL-1:0]       pll_q;
    logic [CHN_TOTAL-1:0]       calib_q;
    logic [CHN_TOTAL-1:0]       srAct_q;
    logic [12*CHN_TOTAL-1:0]    temp_q;
    logic                       pready_q;
    logic                       pslverr_q;
    logic [31:0]                prdata_q;

    logic [CHN_TOTAL-1:0] ctrlWr;
    logic [CHN_TOTAL-1:0] refNow;
    logic [CHN_TOTAL-1:0] zqNow;
    logic [CHN_TOTAL-1:0] clrSticky;
    logic [CHN_TOTAL-1:0] autoLoad;
    logic [CHN_TOTAL-1:0] tempAlarm;
    logic [CHN_TOTAL-1:0] refMissed;
    logic [CHN_TOTAL-1:0] chnIrq;

    logic [11:0] addr;
    logic [1:0]  chnSel;
    logic [3:0]  offSel;
    logic        access;
    logic        isId;
    logic        chnValid;
    logic        regHit;
    logic        wrEn;
    logic [31:0] rdata;
    logic        unusedApb;

    // Gating on pready_q keeps the completion cycle from being taken as a second access.
    assign access    = i_apbi.psel & i_apbi.penable & ~pready_q;
    assign addr      = i_apbi.paddr[11:0];
    assign chnSel    = addr[5:4];
    assign offSel    = addr[3:0];
    assign isId      = (addr == ADDR_ID);
    assign chnValid  = (addr[11:6] == CHN_WINDOW) && (32'(chnSel) < CHN_TOTAL);
    assign regHit    = isId || (chnValid && (offSel inside {OFF_STATUS, OFF_CTRL, OFF_REF_PERIOD, OFF_TEMP_LIMIT}));
    assign wrEn      = access && i_apbi.pwrite && chnValid && regHit;
    assign unusedApb = ^{i_apbi.paddr[31:12], i_apbi.pwdata[31:16]};

    always_comb begin
        rdata = '0;
        if (isId) begin
            rdata = {24'd0, 8'(CHN_TOTAL)};
        end else begin
            for (int c = 0; c < CHN_TOTAL; c++) begin
                if (chnSel == 2'(c)) begin
                    case (offSel)
                        OFF_STATUS:     rdata = {4'd0, temp_q[12*c +: 12], 11'd0, refMissed[c],
                                                 tempAlarm[c], srAct_q[c], calib_q[c], pll_q[c]};
                        OFF_CTRL:       rdata = ctrlReadback(regs_q[c]);
                        OFF_REF_PERIOD: rdata = {16'd0, regs_q[c].ref_period};
                        OFF_TEMP_LIMIT: rdata = {20'd0, regs_q[c].temp_limit};
                        default:        rdata = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pll_q     <= '0;
            calib_q   <= '0;
            srAct_q   <= '0;
            temp_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int c = 0; c < CHN_TOTAL; c++) begin
                regs_q[c]            <= CHN_REGS_RST;
                regs_q[c].ref_period <= REF_PERIOD_RST;
            end
        end else begin
            pll_q    <= i_pll_locked;
            calib_q  <= i_init_calib_done;
            srAct_q  <= i_sr_active;
            temp_q   <= i_device_temp;
            pready_q <= access;
            if (access) begin
                prdata_q  <= (regHit && !i_apbi.pwrite) ? rdata : 32'd0;
                pslverr_q <= !regHit;
            end
            for (int c = 0; c < CHN_TOTAL; c++) begin
                if (wrEn && (chnSel == 2'(c))) begin
                    case (offSel)
                        OFF_CTRL: begin
                            regs_q[c].sr_en       <= i_apbi.pwdata[CTRL_SR_EN];
                            regs_q[c].auto_ref_en <= i_apbi.pwdata[CTRL_AUTO_REF];
                            regs_q[c].irq_en      <= i_apbi.pwdata[CTRL_IRQ_EN];
                        end
                        OFF_REF_PERIOD: regs_q[c].ref_period <= i_apbi.pwdata[15:0];
                        OFF_TEMP_LIMIT: regs_q[c].temp_limit <= i_apbi.pwdata[11:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    for (genvar g = 0; g < CHN_TOTAL; g++) begin : g_chn
        assign ctrlWr[g]    = wrEn && (chnSel == 2'(g)) && (offSel == OFF_CTRL);
        assign refNow[g]    = ctrlWr[g] & i_apbi.pwdata[CTRL_REF_NOW];
        assign zqNow[g]     = ctrlWr[g] & i_apbi.pwdata[CTRL_ZQ_NOW];
        assign clrSticky[g] = ctrlWr[g] & i_apbi.pwdata[CTRL_CLR];
        assign autoLoad[g]  = ctrlWr[g] & i_apbi.pwdata[CTRL_AUTO_REF] & ~regs_q[g].auto_ref_en;
        assign o_sr_req[g]  = regs_q[g].sr_en;

        apb_ddr_mgmt_chn u_chn (
            .clk_i        (i_clk),
            .rst_i        (i_rst),
            .srEn_i       (regs_q[g].sr_en),
            .autoRefEn_i  (regs_q[g].auto_ref_en),
            .irqEn_i      (regs_q[g].irq_en),
            .refPeriod_i  (regs_q[g].ref_period),
            .tempLimit_i  (regs_q[g].temp_limit),
            .deviceTemp_i (temp_q[12*g +: 12]),
            .refNow_i     (refNow[g]),
            .zqNow_i      (zqNow[g]),
            .clrSticky_i  (clrSticky[g]),
            .autoLoad_i   (autoLoad[g]),
            .refAck_i     (i_ref_ack[g]),
            .zqAck_i      (i_zq_ack[g]),
            .refReq_o     (o_ref_req[g]),
            .zqReq_o      (o_zq_req[g]),
            .tempAlarm_o  (tempAlarm[g]),
            .refMissed_o  (refMissed[g]),
            .irq_o        (chnIrq[g])
        );
    end

    assign o_irq = |chnIrq;

    always_comb begin
        o_apbo         = '0;
        o_apbo.prdata  = prdata_q;
        o_apbo.pready  = pready_q;
        o_apbo.pslverr = pslverr_q;
    end

endmodule

// File: doc/apb_ddr_mgmt.md
APB_DDR_MGMT -- requirements
Module: apb_ddr_mgmt

Interface
REQ-001 SHALL have parameter CHN_TOTAL, default 2, number of DDR controller channels managed (1..4).
REQ-002 SHALL have parameter REF_PERIOD_RST, default 16'd7800, reset value of every channel's REF_PERIOD register (clock cycles).
REQ-003 SHALL have port i_clk  in  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port i_rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port i_apbi  in  apb_in_type  APB slave request.
REQ-006 SHALL have port o_apbo  out  apb_out_type  APB slave response.
REQ-007 SHALL have port i_pll_locked  in  CHN_TOTAL  per-channel PLL lock.
REQ-008 SHALL have port i_init_calib_done  in  CHN_TOTAL  per-channel calibration done.
REQ-009 SHALL have port i_device_temp  in  12*CHN_TOTAL  per-channel temperature, channel c at [12c+11:12c].
REQ-010 SHALL have port i_sr_active  in  CHN_TOTAL  self-refresh active status.
REQ-011 SHALL have ports i_ref_ack, i_zq_ack  in  CHN_TOTAL  maintenance acknowledge pulses.
REQ-012 SHALL have ports o_sr_req, o_ref_req, o_zq_req  out  CHN_TOTAL  maintenance requests.
REQ-013 SHALL have port o_irq  out  1  OR of enabled per-channel alarms.

Function
REQ-014 All status inputs SHALL be registered once before use; STATUS reads return the registered values.
REQ-015 APB access SHALL complete with pready=1 exactly one cycle after the access phase (psel&penable); prdata and pslverr are registered.
REQ-016 Address map (paddr[11:0]): 0x000 ID RO {CHN_TOTAL[7:0]}; channel c base 0x040+0x10*c: +0 STATUS RO, +4 CTRL RW, +8 REF_PERIOD RW [15:0], +C TEMP_LIMIT RW [11:0], reset 12'hFFF.
REQ-017 STATUS: bit0 pll_locked, bit1 init_calib_done, bit2 sr_active, bit3 temp_alarm, bit4 ref_missed, [27:16] device_temp.
REQ-018 CTRL: bit0 sr_en (level to o_sr_req), bit1 ref_now (write-1 pulse), bit2 zq_now (write-1 pulse), bit3 auto_ref_en, bit4 irq_en, bit8 W1C clears ref_missed and temp_alarm; reads of bits1,2,8 return 0.
REQ-019 Access to channel c >= CHN_TOTAL or to unlisted offsets SHALL return prdata=0, pslverr=1, no state change.
REQ-020 Per channel, FSM states IDLE, REF, ZQ: IDLE->REF when ref pending; IDLE->ZQ when zq pending and no ref pending (refresh has priority); REF/ZQ hold the matching o_*_req=1 until the ack is sampled 1, then return to IDLE next cycle, clearing that pending flag.
REQ-021 Pending flags SHALL be set by ref_now/zq_now writes or refresh-timer expiry; a request arriving while its flag is set is merged (no queue).
REQ-022 Refresh timer: 16-bit down-counter loaded with REF_PERIOD when auto_ref_en rises or on expiry; expiry at count 0 sets ref pending; expiry while ref pending already set SHALL set sticky ref_missed.
REQ-023 REF_PERIOD=0 SHALL be treated as disabled (no expiry).
REQ-024 temp_alarm SHALL be set (sticky) in any cycle registered device_temp > TEMP_LIMIT.
REQ-025 o_irq = OR over channels of irq_en & (temp_alarm | ref_missed).
REQ-026 If set and clear of a sticky bit coincide, set SHALL win.
REQ-027 While o_sr_req=1 the FSM SHALL NOT leave IDLE; pending flags are retained.

Reset
REQ-028 On i_rst=1: all FSMs IDLE, pending/sticky flags 0, CTRL 0, REF_PERIOD=REF_PERIOD_RST, TEMP_LIMIT=12'hFFF, counters 0, all outputs 0, pready=0; reset mid-handshake drops the request the next cycle.

Structure
REQ-029 Register struct type, its reset constant, address offsets and CTRL bit indices SHALL live in apb_ddr_mgmt_pkg (imports types_amba_pkg).
REQ-030 Per-channel FSM, timer and sticky bits SHALL be one sub-module apb_ddr_mgmt_chn, instantiated CHN_TOTAL times by generate.

Verification
REQ-031 Write CTRL ch0 = 0x2 -> o_ref_req[0]=1 next cycle, held until i_ref_ack[0]=1 pulse, then 0.
REQ-032 ch1 ref_now and zq_now in one write -> REF handshake first, then o_zq_req[1]=1 the cycle after IDLE return.
REQ-033 REF_PERIOD=10, auto_ref_en=1, ack withheld -> o_ref_req at 11 cycles; after 11 more cycles STATUS bit4=1; irq_en=1 -> o_irq=1.
REQ-034 TEMP_LIMIT=0x400, device_temp=0x401 -> STATUS bit3=1 within 2 cycles; write CTRL bit8 with temp back 0x100 -> bit3=0.
REQ-035 Read 0x000 -> 0x2, pready one cycle after access; read 0x0A0 (CHN_TOTAL=2) -> pslverr=1, prdata=0.
REQ-036 Assert i_rst while o_zq_req=1 -> o_zq_req=0 and REF_PERIOD reads 7800 after release.
